// File: rtl/dmem_responder.sv
// Data-memory responder for the multi-cycle CPU: byte-lane word RAM plus a
// small MMIO window (cycle counter, LED register, sticky fault status).
module dmem_responder #(
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter int          RAM_WORDS = 2048,
    parameter logic [31:0] MMIO_BASE = 32'h1002_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  DM_W,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        err,
    output logic [31:0] err_addr
);
    localparam int          NUM_LANES = 4;
    localparam int          IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_WORD = 2'b01,
        ST_HALF = 2'b10,
        ST_BYTE = 2'b11
    } store_t;

    store_t                 st;
    logic [31:0]            ram_off, mmio_off;
    logic                   ram_hit, mmio_hit;
    logic [IDX_W-1:0]       ram_idx;
    logic                   misaligned, fault;
    logic [NUM_LANES-1:0]   lane_we;
    logic [31:0]            wr_word, ram_rd;
    logic [31:0]            cycle_cnt;

    assign st = store_t'(DM_W);

    // Offsets are compared unsigned, so addresses below a base wrap high and miss.
    assign ram_off  = addr - RAM_BASE;
    assign mmio_off = addr - MMIO_BASE;
    assign ram_hit  = (addr >= RAM_BASE)  && (ram_off  < RAM_BYTES);
    assign mmio_hit = (addr >= MMIO_BASE) && (mmio_off < 32'd16);
    assign ram_idx  = ram_off[IDX_W+1:2];

    assign misaligned = ((st == ST_WORD) && (addr[1:0] != 2'b00)) ||
                        ((st == ST_HALF) && addr[0]);

    // Sub-word stores into MMIO are treated as faults just like misalignment.
    assign fault = (st != ST_NONE) &&
                   (misaligned || !(ram_hit || mmio_hit) ||
                    (mmio_hit && (st != ST_WORD)));

    always_comb begin
        lane_we = '0;
        wr_word = wdata;
        case (st)
            ST_WORD: lane_we = 4'b1111;
            ST_HALF: begin
                lane_we = addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata[15:0]}};
            end
            ST_BYTE: begin
                lane_we = 4'b0001 << addr[1:0];
                wr_word = {4{wdata[7:0]}};
            end
            default: lane_we = '0;
        endcase
        if (!ram_hit || fault)
            lane_we = '0;
    end

    // One byte-wide array per lane keeps partial writes simple read-modify-free.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [7:0] mem [RAM_WORDS];

        always_ff @(posedge clk) begin
            if (!reset && lane_we[g])
                mem[ram_idx] <= wr_word[8*g +: 8];
        end

        assign ram_rd[8*g +: 8] = mem[ram_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            led       <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (fault) begin
                err <= 1'b1;
                if (!err)
                    err_addr <= addr;
            end else if (mmio_hit && (st == ST_WORD)) begin
                case (addr[3:2])
                    2'd1:    led <= wdata[15:0];
                    2'd2:    if (wdata[0]) err <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram_rd;
        end else if (mmio_hit) begin
            case (addr[3:2])
                2'd0:    rdata = cycle_cnt;
                2'd1:    rdata = {16'b0, led};
                2'd2:    rdata = {31'b0, err};
                default: rdata = err_addr;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM lane writes, MMIO
// registers, fault capture, counter wrap and reset behaviour.
module tb_dmem_responder;
    localparam logic [31:0] MMIO = 32'h1002_0000;

    logic        clk;
    logic        reset;
    logic [31:0] addr, wdata, rdata, err_addr;
    logic [1:0]  DM_W;
    logic [15:0] led;
    logic        err;
    int          checks = 0;
    int          errors = 0;

    dmem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .DM_W     (DM_W),
        .rdata    (rdata),
        .led      (led),
        .err      (err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one store across a single rising edge, then idle the port.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        addr = a; wdata = d; DM_W = w;
        @(negedge clk);
        DM_W = 2'b00; wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; DM_W = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_led", {16'b0, led}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);

        // Counter counts 0,1,2,... from reset release.
        reset = 1'b0;
        addr  = MMIO;
        #1 check("cnt0", rdata, 32'd0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("cnt%0d", i), rdata, 32'(i));
        end
        rd("mmio_led0", MMIO + 32'h4, 32'h0);
        rd("mmio_err0", MMIO + 32'h8, 32'h0);
        rd("mmio_eaddr0", MMIO + 32'hC, 32'h0);
        rd("miss_zero", 32'h0000_0000, 32'h0);
        rd("miss_past_mmio", MMIO + 32'h10, 32'h0);
        rd("miss_past_ram", 32'h1001_2000, 32'h0);

        // Byte-lane merge.
        store(32'h1001_0000, 32'hDEAD_BEEF, 2'b01);
        store(32'h1001_0001, 32'h0000_0055, 2'b11);
        store(32'h1001_0002, 32'h0000_1234, 2'b10);
        rd("lane_merge", 32'h1001_0000, 32'h1234_55EF);
        check("lane_merge_err", {31'b0, err}, 32'h0);

        // Old data visible until the edge, new data right after.
        store(32'h1001_0004, 32'hCAFE_F00D, 2'b01);
        @(negedge clk);
        addr = 32'h1001_0004; wdata = 32'h1122_3344; DM_W = 2'b01;
        #1 check("no_forward", rdata, 32'hCAFE_F00D);
        @(negedge clk);
        DM_W = 2'b00;
        #1 check("after_edge", rdata, 32'h1122_3344);

        store(32'h1001_1FFC, 32'hA5A5_A5A5, 2'b01);
        rd("last_word", 32'h1001_1FFC, 32'hA5A5_A5A5);

        // Misaligned word write is dropped and captured.
        store(32'h1001_0006, 32'hFFFF_FFFF, 2'b01);
        rd("misal_unchanged", 32'h1001_0004, 32'h1122_3344);
        check("misal_err", {31'b0, err}, 32'h1);
        check("misal_eaddr", err_addr, 32'h1001_0006);

        // Second fault keeps the first address.
        store(32'h0000_0040, 32'h0000_00AA, 2'b11);
        check("sticky_eaddr", err_addr, 32'h1001_0006);
        rd("mmio_err_rd", MMIO + 32'h8, 32'h1);
        rd("mmio_eaddr_rd", MMIO + 32'hC, 32'h1001_0006);

        // W1C with bit0 clear does nothing; with bit0 set clears err only.
        store(MMIO + 32'h8, 32'h0000_0002, 2'b01);
        check("w1c_noop", {31'b0, err}, 32'h1);
        store(MMIO + 32'h8, 32'h0000_0001, 2'b01);
        check("w1c_clear", {31'b0, err}, 32'h0);
        check("w1c_keep_eaddr", err_addr, 32'h1001_0006);
        store(32'h0000_0000, 32'h0000_1111, 2'b10);
        check("refault_err", {31'b0, err}, 32'h1);
        check("refault_eaddr", err_addr, 32'h0);

        // LED register, read-only regs and sub-word MMIO stores.
        store(MMIO + 32'h8, 32'h1, 2'b01);
        store(MMIO + 32'h4, 32'hABCD_1234, 2'b01);
        check("led_write", {16'b0, led}, 32'h1234);
        rd("led_rd", MMIO + 32'h4, 32'h0000_1234);
        store(MMIO, 32'h5, 2'b01);
        store(MMIO + 32'hC, 32'h5, 2'b01);
        check("ro_no_err", {31'b0, err}, 32'h0);
        store(MMIO + 32'h4, 32'h0000_00FF, 2'b11);
        check("sb_mmio_led", {16'b0, led}, 32'h1234);
        check("sb_mmio_err", {31'b0, err}, 32'h1);
        check("sb_mmio_eaddr", err_addr, MMIO + 32'h4);

        // Odd halfword and just-past-RAM word.
        store(MMIO + 32'h8, 32'h1, 2'b01);
        store(32'h1001_0001, 32'h0000_BBBB, 2'b10);
        check("sh_odd_eaddr", err_addr, 32'h1001_0001);
        rd("sh_odd_unchanged", 32'h1001_0000, 32'h1234_55EF);
        store(MMIO + 32'h8, 32'h1, 2'b01);
        store(32'h1001_2000, 32'h0000_0001, 2'b01);
        check("ram_end_eaddr", err_addr, 32'h1001_2000);

        // Counter wrap.
        @(negedge clk);
        dut.cycle_cnt = 32'hFFFF_FFFE;
        addr = MMIO;
        #1 check("cnt_fffe", rdata, 32'hFFFF_FFFE);
        @(negedge clk);
        #1 check("cnt_ffff", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 check("cnt_wrap", rdata, 32'h0);

        // Reset coincident with a store drops the store.
        store(32'h1001_0010, 32'h0000_0077, 2'b01);
        @(negedge clk);
        addr = 32'h1001_0010; wdata = 32'h1; DM_W = 2'b01; reset = 1'b1;
        #1;
        check("rst_mid_led", {16'b0, led}, 32'h0);
        check("rst_mid_err", {31'b0, err}, 32'h0);
        @(negedge clk);
        DM_W = 2'b00; reset = 1'b0;
        rd("rst_cnt", MMIO, 32'h0);
        check("rst_eaddr", err_addr, 32'h0);
        rd("rst_dropped_wr", 32'h1001_0010, 32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's data port; it is the other end of the `addr`/`wdata`/`DM_W`/`rdata` interface.
- Decodes `DM_W` store requests into byte-lane writes on an internal word RAM.
- Returns aligned read words; the CPU's load-transform unit does sub-word extraction.
- Also hosts a small MMIO window: free-running cycle counter, LED register, sticky misaligned/out-of-range error status.

Parameters:
- `RAM_BASE`, 32'h1001_0000, byte address of RAM word 0.
- `RAM_WORDS`, 2048, RAM depth in 32-bit words (power of two).
- `MMIO_BASE`, 32'h1002_0000, byte address of the MMIO window (16 bytes).

Ports:
- `clk`  input  1  system clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `addr`  input  32  byte address from CPU
- `wdata`  input  32  store data from CPU; sub-word data is in the low bits
- `DM_W`  input  2  store request: 00 none, 01 word, 10 halfword, 11 byte
- `rdata`  output  32  aligned word at `addr & ~3`, combinational
- `led`  output  16  LED register value
- `err`  output  1  sticky error flag
- `err_addr`  output  32  address of the first faulting access since the error was last cleared

Behaviour:
- Reset (async, active-high) clears `led`, `err`, `err_addr` and the cycle counter to 0. RAM contents are not cleared.
- Decode:
  - RAM hit when `RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS`; index = `(addr - RAM_BASE) >> 2`.
  - MMIO hit when `MMIO_BASE <= addr < MMIO_BASE + 16`; register = `addr[3:2]`.
  - Anything else is a miss.
- Reads: `rdata` is a combinational function of `addr` and current state.
  - RAM hit: the stored word.
  - MMIO reg 0 = counter; reg 1 = {16'b0, `led`}; reg 2 = {31'b0, `err`}; reg 3 = `err_addr`.
  - Miss: 32'h0000_0000. A read never sets `err`.
- Writes occur on the clock edge while `DM_W != 00`, little-endian:
  - Word: all four lanes ← `wdata`.
  - Halfword: lanes {`addr[1]`*2+1, `addr[1]`*2} ← `wdata[15:0]`; other lanes unchanged.
  - Byte: lane `addr[1:0]` ← `wdata[7:0]`; other lanes unchanged.
- Misalignment (word with `addr[1:0] != 0`, or halfword with `addr[0] = 1`):
  - the write is suppressed;
  - `err` ← 1;
  - `err_addr` ← `addr`, only if `err` was 0 before this edge.
- Write to a miss address: suppressed, error handling identical to misalignment.
- MMIO writes must be word writes; halfword/byte stores to MMIO count as misaligned.
  - Reg 0 (counter): write ignored, no error.
  - Reg 1: `led` ← `wdata[15:0]`.
  - Reg 2: write-1-to-clear; `wdata[0] = 1` clears `err`. `err_addr` is retained until the next first fault.
  - Reg 3: write ignored, no error.
- Simultaneous events:
  - A new fault in the same cycle as a W1C of `err` cannot occur, because a single request is one access.
  - A fault on the first edge after a clear captures the new `err_addr`.
- Counter:
  - increments by 1 every clock while not in reset;
  - wraps 32'hFFFF_FFFF → 0;
  - a read returns the pre-edge value.
- Write-then-read: after a write at edge N, a read of the same address returns the new data starting in the cycle after edge N. There is no forwarding within the write cycle; `rdata` shows the old value until the edge.
- Reset asserted mid-operation: a pending write on that edge is dropped; registers follow reset immediately.

Test Plan:
- Reset, then read 0x1002_0000 over 5 cycles → values 0..4 consecutively; reads of 0x1002_0004/8/C → 0.
- SW 0x1001_0000 ← 0xDEADBEEF; SB 0x1001_0001 ← 0x55; SH 0x1001_0002 ← 0x1234 → read 0x1001_0000 returns 0x123455EF; `err` = 0.
- SW to 0x1001_0006 with 0xFFFFFFFF → RAM word unchanged; `err` = 1; `err_addr` = 0x1001_0006. A following SB to 0x0000_0040 leaves `err_addr` at 0x1001_0006.
- SW 0x1002_0008 ← 1 → `err` = 0. Then SH to 0x0 → `err` = 1, `err_addr` = 0x0000_0000.
- SW 0x1002_0004 ← 0xABCD1234 → `led` = 0x1234. SB to 0x1002_0004 → `led` unchanged, `err` = 1.
- Force counter to 0xFFFFFFFE via hierarchical deposit, clock 2 → reads 0xFFFFFFFF then 0x0. Assert reset coincident with SW 0x1001_0010 ← 0x1 → that word is unchanged and counter/`led`/`err` = 0.
